fp32_subtractor_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision subtractor computing op_a - op_b; the inverse-operation companion to the team's combinational FP32 adder.
- Trades area for latency: one alignment shifter bit and one normalisation shifter bit per cycle, driven by an FSM.
- Uses valid/ready handshakes on input and output, so it drops into streaming datapaths.
- Rounding is round-to-nearest-even; NaN encoding matches the adder (0x7FC00000).

---
 rtl/fp32_subtractor_seq_if.sv | 18 +
 rtl/fp32_subtractor_seq.sv | 157 +++++++++++++++
 tb/tb_fp32_subtractor_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/fp32_subtractor_seq_if.sv
// fp32_subtractor_seq_if: operand/result valid-ready bundle; flags present only with FP32_SUB_FLAGS_EN
interface fp32_subtractor_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
`ifdef FP32_SUB_FLAGS_EN
   logic [3:0]  flags;
   modport master(output in_valid, op_a, op_b, out_ready, input in_ready, out_valid, result, flags);
   modport slave(input in_valid, op_a, op_b, out_ready, output in_ready, out_valid, result, flags);
`else
   modport master(output in_valid, op_a, op_b, out_ready, input in_ready, out_valid, result);
   modport slave(input in_valid, op_a, op_b, out_ready, output in_ready, out_valid, result);
`endif
endinterface

// File: rtl/fp32_subtractor_seq.sv
// fp32_subtractor_seq: multi-cycle FP32 op_a - op_b, RNE, one shift per cycle.
// Optional FP32_SUB_FLAGS_EN adds flags {invalid, overflow, underflow, inexact}.
module fp32_subtractor_seq #(
   parameter int MAX_ALIGN = 27
) (
   input  logic clk,
   input  logic rst,
   fp32_subtractor_seq_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CLASSIFY, ALIGN, ADDSUB, NORM, ROUND, DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic        sign_q, sign_d, eff_sub_q, eff_sub_d, sticky_q, sticky_d;
   logic [9:0]  exp_q, exp_d;
   logic [7:0]  diff_q, diff_d;
   logic [23:0] large_q, large_d;
   logic [25:0] small_q, small_d;
   logic [27:0] mant_q, mant_d;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, invalid, swap;
   logic [7:0]  ea, eb, diff_c;
   logic [23:0] sa, sb, sm_sig;
   logic [27:0] sum;
   logic        rnd_up, ovf;
   logic [24:0] rnd;
   logic [9:0]  rexp;
   // b already carries the inverted sign, so everything below is an effective addition
   assign a_nan   = &a_q[30:23] && |a_q[22:0];
   assign b_nan   = &b_q[30:23] && |b_q[22:0];
   assign a_inf   = &a_q[30:23] && !(|a_q[22:0]);
   assign b_inf   = &b_q[30:23] && !(|b_q[22:0]);
   assign a_zero  = !(|a_q[30:0]);
   assign b_zero  = !(|b_q[30:0]);
   assign invalid = a_nan || b_nan || (a_inf && b_inf && a_q[31] != b_q[31]);
   assign ea      = |a_q[30:23] ? a_q[30:23] : 8'd1;
   assign eb      = |b_q[30:23] ? b_q[30:23] : 8'd1;
   assign sa      = {|a_q[30:23], a_q[22:0]};
   assign sb      = {|b_q[30:23], b_q[22:0]};
   assign swap    = {eb, sb} > {ea, sa};
   assign diff_c  = swap ? eb - ea : ea - eb;
   assign sm_sig  = swap ? sa : sb;
   assign sum     = eff_sub_q ? {1'b0, large_q, 3'b000} - {1'b0, small_q, sticky_q}
                              : {1'b0, large_q, 3'b000} + {1'b0, small_q, sticky_q};
   // mant_q[26:3] is the significand, [2:0] are guard, round, sticky
   assign rnd_up  = mant_q[2] && (mant_q[1] || mant_q[0] || mant_q[3]);
   assign rnd     = {1'b0, mant_q[26:3]} + {24'd0, rnd_up};
   assign rexp    = rnd[24] ? exp_q + 10'd1 : (rnd[23] ? exp_q : 10'd0);
   assign ovf     = rexp >= 10'd255;
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      sign_d    = sign_q;
      eff_sub_d = eff_sub_q;
      sticky_d  = sticky_q;
      exp_d     = exp_q;
      diff_d    = diff_q;
      large_d   = large_q;
      small_d   = small_q;
      mant_d    = mant_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.op_a;
               b_d     = {~bus.op_b[31], bus.op_b[30:0]};
               state_d = CLASSIFY;
            end
         end
         CLASSIFY: begin
            state_d   = DONE;
            sign_d    = swap ? b_q[31] : a_q[31];
            eff_sub_d = a_q[31] != b_q[31];
            exp_d     = {2'b00, swap ? eb : ea};
            large_d   = swap ? sb : sa;
            diff_d    = diff_c;
            small_d   = {sm_sig, 2'b00};
            sticky_d  = 1'b0;
            if (invalid) result_d = 32'h7FC0_0000;
            else if (a_inf) result_d = a_q;
            else if (b_inf) result_d = b_q;
            else if (a_zero && b_zero) result_d = {a_q[31] & b_q[31], 31'd0};
            else if (a_zero) result_d = b_q;
            else if (b_zero) result_d = a_q;
            else if (32'(diff_c) >= MAX_ALIGN) begin
               small_d  = 26'd0;
               sticky_d = |sm_sig;
               state_d  = ADDSUB;
            end else state_d = diff_c == 8'd0 ? ADDSUB : ALIGN;
         end
         ALIGN: begin
            small_d  = small_q >> 1;
            sticky_d = sticky_q | small_q[0];
            diff_d   = diff_q - 8'd1;
            state_d  = diff_q == 8'd1 ? ADDSUB : ALIGN;
         end
         ADDSUB: begin
            mant_d   = sum;
            result_d = 32'd0;
            state_d  = sum == 28'd0 ? DONE : NORM;
         end
         NORM: begin
            if (mant_q[27]) begin
               mant_d  = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
               exp_d   = exp_q + 10'd1;
               state_d = ROUND;
            end else if (!mant_q[26] && exp_q > 10'd1) begin
               mant_d = mant_q << 1;
               exp_d  = exp_q - 10'd1;
            end else state_d = ROUND;
         end
         ROUND: begin
            result_d = ovf ? {sign_q, 8'hFF, 23'd0}
                           : {sign_q, rexp[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
            state_d  = DONE;
         end
         DONE: state_d = bus.out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      sticky_q  <= sticky_d;
      exp_q     <= exp_d;
      diff_q    <= diff_d;
      large_q   <= large_d;
      small_q   <= small_d;
      mant_q    <= mant_d;
   end
   assign bus.in_ready  = state_q == IDLE;
   assign bus.out_valid = state_q == DONE;
   assign bus.result    = result_q;
`ifdef FP32_SUB_FLAGS_EN
   logic [3:0] flags_q, flags_d;
   logic       inx;
   assign inx = |mant_q[2:0] || ovf;
   always_comb begin
      flags_d = state_q == IDLE     ? 4'd0 :
                state_q == CLASSIFY ? {invalid, 3'b000} :
                state_q == ROUND    ? {1'b0, ovf, !ovf && rexp == 10'd0 && inx, inx} : flags_q;
   end
   always_ff @(posedge clk) begin
      if (rst) flags_q <= 4'd0;
      else flags_q <= flags_d;
   end
   assign bus.flags = flags_q;
`endif
endmodule

// File: tb/tb_fp32_subtractor_seq.sv
// tb_fp32_subtractor_seq: vector table plus scoreboard queue, handshake-hold and mid-ALIGN reset cases
module tb_fp32_subtractor_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   fp32_subtractor_seq_if bus();
   fp32_subtractor_seq #(.MAX_ALIGN(27)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [3:0]  f;
      int          hold;
      bit          spc;
   } vec_t;
   vec_t vecs[$];
   vec_t sb[$];
   int errors = 0;
   int checks = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic run_op(input vec_t v);
      vec_t e;
      int lat = 0;
      sb.push_back(v);
      @(negedge clk);
      bus.op_a = v.a;
      bus.op_b = v.b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("accept", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (v.spc) check("special_latency", lat, 32'd2);
      else check("latency_le_55", 32'(lat <= 55), 32'd1);
      for (int i = 0; i < v.hold; i++) begin
         check("hold_result", bus.result, v.r);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      e = sb.pop_front();
      check($sformatf("result %h-%h", e.a, e.b), bus.result, e.r);
`ifdef FP32_SUB_FLAGS_EN
      check($sformatf("flags %h-%h", e.a, e.b), 32'(bus.flags), 32'(e.f));
`endif
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("out_valid_clear", 32'(bus.out_valid), 32'd0);
      check("in_ready_back", 32'(bus.in_ready), 32'd1);
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.op_a = 32'd0;
      bus.op_b = 32'd0;
      vecs.push_back('{32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000, 5, 1'b0});
      vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000, 0, 1'b0});
      vecs.push_back('{32'hBF800000, 32'hBF800000, 32'h00000000, 4'b0000, 0, 1'b0});
      vecs.push_back('{32'h3F800000, 32'h33000000, 32'h3F800000, 4'b0001, 0, 1'b0});
      vecs.push_back('{32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 4'b0000, 0, 1'b0});
      vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 0, 1'b1});
      vecs.push_back('{32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000, 0, 1'b1});
      vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 0, 1'b1});
      vecs.push_back('{32'h3F800000, 32'hFF800000, 32'h7F800000, 4'b0000, 0, 1'b1});
      vecs.push_back('{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4'b0101, 0, 1'b0});
      vecs.push_back('{32'h00800000, 32'h00400000, 32'h00400000, 4'b0000, 0, 1'b0});
      vecs.push_back('{32'h00000000, 32'h00000000, 32'h00000000, 4'b0000, 0, 1'b1});
      vecs.push_back('{32'h80000000, 32'h00000000, 32'h80000000, 4'b0000, 0, 1'b1});
      vecs.push_back('{32'h00000000, 32'h3F800000, 32'hBF800000, 4'b0000, 0, 1'b1});
      vecs.push_back('{32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000, 0, 1'b0});
      vecs.push_back('{32'h40000000, 32'hBF800000, 32'h40400000, 4'b0000, 0, 1'b0});
      vecs.push_back('{32'h3F800000, 32'h00000001, 32'h3F800000, 4'b0001, 0, 1'b0});
      vecs.push_back('{32'h3F800001, 32'h3F800000, 32'h34000000, 4'b0000, 0, 1'b0});
      vecs.push_back('{32'h00800001, 32'h00800000, 32'h00000001, 4'b0000, 0, 1'b0});
      vecs.push_back('{32'h4B800000, 32'h3F000000, 32'h4B800000, 4'b0001, 0, 1'b0});
      repeat (3) @(negedge clk);
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_result", bus.result, 32'd0);
      rst = 1'b0;
      foreach (vecs[i]) run_op(vecs[i]);
      @(negedge clk);
      bus.op_a = 32'h3F800000;
      bus.op_b = 32'h33000000;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      run_op(vecs[0]);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
